pll_clk_monitor: RTL
====================

# pll_clk_monitor

Downstream companion to the 8X PLL. Runs on the multiplied clock and checks the PLL output against its reference: it measures clk cycles per ref_clk period and qualifies the PLL `locked` flag. Once both are stable, it releases a synchronised reset to the core logic. On any later loss of lock or ratio error it re-asserts that reset and flags the fault.

## Interface
- RATIO, 8 — expected clk cycles per ref_clk period
- TOL, 1 — allowed ± deviation from RATIO, in cycles
- STABLE_PERIODS, 4 — consecutive good periods required before the reset hold starts
- RST_HOLD, 16 — clk cycles rst_out_n stays low after qualification
- clk  in  1  PLL out_clk; the only clock
- RST_n  in  1  asynchronous active-low reset
- ref_clk  in  1  PLL reference clock; asynchronous to clk and sampled as data
- locked  in  1  PLL lock flag; asynchronous
- clr_err  in  1  synchronous clear of err
- rst_out_n  out  1  reset for core logic; low = in reset
- good  out  1  high only in RUN
- err  out  1  sticky fault flag
- period_cnt  out  8  last measured period, in clk cycles

## Operation
- Synchronisers:
  - ref_clk passes through 2 flops; a 3rd flop provides rising-edge detect (ref_rise).
  - locked passes through 2 flops (locked_s).
- Period counter:
  - 8 bits; increments every clk.
  - On ref_rise: loads 1, and the previous count latches into period_cnt.
  - Saturates at 255. Saturation counts as a bad period (ref_clk stopped).
- A period is good when RATIO−TOL ≤ count ≤ RATIO+TOL (unsigned compare).
- FSM states and transitions:
  - IDLE: wait for locked_s = 1, then go to SYNC.
  - SYNC: wait for the first ref_rise (the partial period is discarded), then go to MEASURE with the good-count cleared.
  - MEASURE:
    - Each ref_rise with a good period increments the good-count; a bad period clears it and stays in MEASURE.
    - At good-count = STABLE_PERIODS, go to HOLD.
    - locked_s = 0 returns to IDLE without setting err.
  - HOLD: count RST_HOLD cycles, then go to RUN. A bad period or locked_s = 0 goes to FAULT.
  - RUN: rst_out_n = 1 and good = 1. A bad period or locked_s = 0 goes to FAULT.
  - FAULT: one cycle; sets err, then goes to IDLE.
- rst_out_n = 1 only in RUN. good equals (state == RUN).
- err setting and clearing:
  - err is set on entry to FAULT and cleared by clr_err.
  - If clr_err and FAULT entry occur in the same cycle, set wins.
- Simultaneous events:
  - If a bad period and locked_s low occur in the same cycle, enter FAULT once.
  - If ref_rise and counter saturation coincide, ref_rise takes priority and the count is evaluated.

## Timing
- Reset values: rst_out_n = 0, good = 0, err = 0, period_cnt = 0, state = IDLE, counters = 0.
- RST_n assertion mid-operation forces all reset values immediately (asynchronous). Deassertion is taken on the next clk edge.
- ref_clk rise to ref_rise: 3 clk edges. period_cnt updates 1 cycle after ref_rise.
- locked fall to FAULT entry: 3 clk edges, plus 1 more to reach IDLE. rst_out_n falls on the FAULT entry edge.
- Bad period detected to rst_out_n low: 1 cycle (the FAULT entry edge).
- HOLD is exactly RST_HOLD cycles. rst_out_n rises on the HOLD→RUN edge.
- Minimum locked-to-release time: 3 + (STABLE_PERIODS+1) ref periods + RST_HOLD + 1 clk.

## Configuration
- PLL_MON_STATS_EN defined:
  - Adds output fault_cnt (8 bits), an 8-bit counter incremented on each FAULT entry.
  - Saturates at 255, is cleared by clr_err, and resets to 0.
- PLL_MON_STATS_EN undefined: the fault_cnt port and counter are absent. All other behaviour is identical.

## Test plan
- Nominal lock:
  - Stimulus: ref_clk period 200 units, clk period 25, locked rises at t = 1000.
  - Response: period_cnt = 8. rst_out_n rises after SYNC, 4 good periods and 16 HOLD cycles; good = 1, err = 0.
- Ratio error in RUN:
  - Stimulus: switch the clk period to 20 (count 10).
  - Response: FAULT on the first 10-count edge, rst_out_n = 0 next edge, err = 1, state returns to IDLE.
- Lock loss:
  - Stimulus: drop locked in RUN.
  - Response: rst_out_n low on the 3rd clk edge after; err = 1. Dropping locked in MEASURE instead gives err = 0.
- Stopped reference:
  - Stimulus: hold ref_clk low in RUN.
  - Response: counter saturates at 255, FAULT entered, err = 1.
- clr_err vs fault:
  - Stimulus: assert clr_err in the same cycle as FAULT entry.
  - Response: err stays 1. clr_err alone on a later cycle clears err.
- Mid-operation reset:
  - Stimulus: pulse RST_n low during HOLD.
  - Response: all outputs at reset values immediately; a full requalification is required. With PLL_MON_STATS_EN, fault_cnt = 0 after the reset and equals 2 after two forced faults.

Source files
------------

// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor
// Runs on the PLL output clock. Measures clk cycles per ref_clk period,
// qualifies the PLL locked flag, and releases a reset to the core logic once
// both have been stable. Any later loss of lock or ratio error pulls the
// reset back low and raises a sticky err flag.
// Optional build macro: PLL_MON_STATS_EN adds an 8-bit saturating fault_cnt
// output counting FAULT entries.
`timescale 1ns/1ps
module pll_clk_monitor #(
  parameter int unsigned RATIO          = 8,
  parameter int unsigned TOL            = 1,
  parameter int unsigned STABLE_PERIODS = 4,
  parameter int unsigned RST_HOLD       = 16
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       ref_clk,
  input  logic       locked,
  input  logic       clr_err,
  output logic       rst_out_n,
  output logic       good,
  output logic       err,
`ifdef PLL_MON_STATS_EN
  output logic [7:0] fault_cnt,
`endif
  output logic [7:0] period_cnt
);

  localparam int unsigned GW = $clog2(STABLE_PERIODS + 1);
  localparam int unsigned HW = $clog2(RST_HOLD + 1);

  localparam logic [7:0]    PER_MIN   = 8'(RATIO - TOL);
  localparam logic [7:0]    PER_MAX   = 8'(RATIO + TOL);
  localparam logic [7:0]    CNT_MAX   = 8'hFF;
  localparam logic [GW-1:0] GOOD_LAST = GW'(STABLE_PERIODS - 1);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_MEASURE = 3'd2,
    S_HOLD    = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  logic          ref_meta_q, ref_sync_q, ref_dly_q;
  logic          lock_meta_q, lock_s_q;
  logic          ref_rise_s;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    period_q, period_d;
  logic          period_ok_s, period_good_s, period_bad_s;
  state_t        state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          fault_entry_s;
  logic          err_q, err_d;
  logic          rst_out_n_q, good_q;

  // Bring ref_clk and locked into the clk domain; the third ref flop marks the rising edge.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      ref_meta_q  <= 1'b0;
      ref_sync_q  <= 1'b0;
      ref_dly_q   <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      ref_meta_q  <= ref_clk;
      ref_sync_q  <= ref_meta_q;
      ref_dly_q   <= ref_sync_q;
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign ref_rise_s = ref_sync_q & ~ref_dly_q;

  // Period counter: restart at 1 on each reference edge (latching the old count), hold at full scale.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (ref_rise_s) begin
      cnt_d    = 8'd1;
      period_d = cnt_q;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = cnt_q;
      period_d = period_q;
    end else begin
      cnt_d    = cnt_q + 8'd1;
      period_d = period_q;
    end
  end

  assign period_ok_s   = (cnt_q >= PER_MIN) && (cnt_q <= PER_MAX);
  assign period_good_s = ref_rise_s & period_ok_s;
  // A closed period out of range is bad; so is a saturated counter with no edge (reference stopped).
  assign period_bad_s  = ref_rise_s ? ~period_ok_s : (cnt_q == CNT_MAX);

  // Next-state logic for lock qualification, reset hold and fault handling.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    hold_cnt_d = {HW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (lock_s_q) state_d = S_SYNC;
        else          state_d = S_IDLE;
      end
      S_SYNC: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
        end else if (ref_rise_s) begin
          // The partial period before this edge is thrown away.
          state_d    = S_MEASURE;
          good_cnt_d = {GW{1'b0}};
        end else begin
          state_d = S_SYNC;
        end
      end
      S_MEASURE: begin
        if (!lock_s_q) begin
          state_d = S_IDLE;
        end else if (period_good_s) begin
          if (good_cnt_q == GOOD_LAST) state_d = S_HOLD;
          else                         good_cnt_d = good_cnt_q + GOOD_ONE;
        end else if (period_bad_s) begin
          good_cnt_d = {GW{1'b0}};
        end else begin
          state_d = S_MEASURE;
        end
      end
      S_HOLD: begin
        if (!lock_s_q || period_bad_s) begin
          state_d = S_FAULT;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          state_d    = S_HOLD;
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      S_RUN: begin
        if (!lock_s_q || period_bad_s) state_d = S_FAULT;
        else                           state_d = S_RUN;
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fault_entry_s = (state_d == S_FAULT) && (state_q != S_FAULT);

  // Sticky error: a new fault wins over a simultaneous clear.
  always_comb begin
    if (fault_entry_s)  err_d = 1'b1;
    else if (clr_err)   err_d = 1'b0;
    else                err_d = err_q;
  end

  // State, counters and flags; status outputs track the next state so they move on the transition edge.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q       <= 8'd0;
      period_q    <= 8'd0;
      state_q     <= S_IDLE;
      good_cnt_q  <= {GW{1'b0}};
      hold_cnt_q  <= {HW{1'b0}};
      err_q       <= 1'b0;
      rst_out_n_q <= 1'b0;
      good_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      err_q       <= err_d;
      rst_out_n_q <= (state_d == S_RUN);
      good_q      <= (state_d == S_RUN);
    end
  end

`ifdef PLL_MON_STATS_EN
  logic [7:0] fault_cnt_q, fault_cnt_d;

  // Fault statistics: count FAULT entries, saturate, cleared together with err.
  always_comb begin
    if (fault_entry_s) begin
      if (fault_cnt_q == CNT_MAX) fault_cnt_d = fault_cnt_q;
      else                        fault_cnt_d = fault_cnt_q + 8'd1;
    end else if (clr_err) begin
      fault_cnt_d = 8'd0;
    end else begin
      fault_cnt_d = fault_cnt_q;
    end
  end

  // Fault statistics register.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) fault_cnt_q <= 8'd0;
    else        fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt = fault_cnt_q;
`else
  // Fault statistics are not built in this configuration.
`endif

  assign rst_out_n  = rst_out_n_q;
  assign good       = good_q;
  assign err        = err_q;
  assign period_cnt = period_q;

endmodule
